// File: rtl/operand_forward_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : operand_forward_stage_if
// Purpose  : ID, MEM, WB and EX signal bundle for the ID/EX operand stage.
// Revision : 1.0
// ============================================================================
interface operand_forward_stage_if #(
    parameter int XLEN = 32,
    parameter int REGW = 5
);
    logic            stall_in;
    logic            flush_in;
    logic            id_valid;
    logic [REGW-1:0] id_rs1;
    logic [REGW-1:0] id_rs2;
    logic            id_use_rs1;
    logic            id_use_rs2;
    logic [XLEN-1:0] id_rdata1;
    logic [XLEN-1:0] id_rdata2;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_imm;
    logic            id_asel;
    logic            id_bsel;
    logic [REGW-1:0] id_rd;
    logic            id_we;
    logic            id_is_load;
    logic [REGW-1:0] mem_rd;
    logic            mem_we;
    logic            mem_is_load;
    logic [XLEN-1:0] mem_result;
    logic [REGW-1:0] wb_rd;
    logic            wb_we;
    logic [XLEN-1:0] wb_data;
    logic            ex_valid;
    logic [REGW-1:0] ex_rd;
    logic            ex_we;
    logic            ex_is_load;
    logic [XLEN-1:0] ex_opa;
    logic [XLEN-1:0] ex_opb;
    logic [XLEN-1:0] ex_store_data;
    logic [2:0]      fwd_sel_a;
    logic [2:0]      fwd_sel_b;
    logic            hazard_stall;

    modport master (
        output stall_in, flush_in, id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rdata1, id_rdata2, id_pc, id_imm, id_asel, id_bsel, id_rd, id_we,
               id_is_load, mem_rd, mem_we, mem_is_load, mem_result, wb_rd, wb_we, wb_data,
        input  ex_valid, ex_rd, ex_we, ex_is_load, ex_opa, ex_opb, ex_store_data,
               fwd_sel_a, fwd_sel_b, hazard_stall
    );

    modport slave (
        input  stall_in, flush_in, id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rdata1, id_rdata2, id_pc, id_imm, id_asel, id_bsel, id_rd, id_we,
               id_is_load, mem_rd, mem_we, mem_is_load, mem_result, wb_rd, wb_we, wb_data,
        output ex_valid, ex_rd, ex_we, ex_is_load, ex_opa, ex_opb, ex_store_data,
               fwd_sel_a, fwd_sel_b, hazard_stall
    );
endinterface
`default_nettype wire

// File: rtl/operand_forward_stage.sv
`default_nettype none
// ============================================================================
// Module   : operand_forward_stage
// Purpose  : ID/EX operand register with MEM/WB/history forwarding and
//            load-use interlock.
// Revision : 1.0
// ============================================================================
module operand_forward_stage #(
    parameter int XLEN       = 32,
    parameter int REGW       = 5,
    parameter int HIST_DEPTH = 2
) (
    input  wire logic               clk,
    input  wire logic               rst,
    operand_forward_stage_if.slave  bus
);
    localparam logic [2:0] c_SEL_REG  = 3'd0;
    localparam logic [2:0] c_SEL_MEM  = 3'd1;
    localparam logic [2:0] c_SEL_WB   = 3'd2;
    localparam logic [2:0] c_SEL_HIST = 3'd3;

    logic            r_ex_valid;
    logic [REGW-1:0] r_rs1;
    logic [REGW-1:0] r_rs2;
    logic [XLEN-1:0] r_rdata1;
    logic [XLEN-1:0] r_rdata2;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_imm;
    logic            r_asel;
    logic            r_bsel;
    logic [REGW-1:0] r_rd;
    logic            r_we;
    logic            r_is_load;

    logic            r_hist_valid [HIST_DEPTH];
    logic [REGW-1:0] r_hist_rd    [HIST_DEPTH];
    logic [XLEN-1:0] r_hist_data  [HIST_DEPTH];

    logic            w_hazard;
    logic [XLEN+2:0] w_res_a;
    logic [XLEN+2:0] w_res_b;

    assign w_hazard = bus.id_valid && r_ex_valid && r_is_load && (r_rd != '0) &&
                      ((bus.id_use_rs1 && (bus.id_rs1 == r_rd)) ||
                       (bus.id_use_rs2 && (bus.id_rs2 == r_rd)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_valid <= 1'b0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rdata1   <= '0;
            r_rdata2   <= '0;
            r_pc       <= '0;
            r_imm      <= '0;
            r_asel     <= 1'b0;
            r_bsel     <= 1'b0;
            r_rd       <= '0;
            r_we       <= 1'b0;
            r_is_load  <= 1'b0;
        end else if (bus.flush_in) begin
            r_ex_valid <= 1'b0;
            r_we       <= 1'b0;
        end else if (!bus.stall_in) begin
            if (w_hazard) begin
                r_ex_valid <= 1'b0;
                r_we       <= 1'b0;
            end else begin
                r_ex_valid <= bus.id_valid;
                r_rs1      <= bus.id_rs1;
                r_rs2      <= bus.id_rs2;
                r_rdata1   <= bus.id_rdata1;
                r_rdata2   <= bus.id_rdata2;
                r_pc       <= bus.id_pc;
                r_imm      <= bus.id_imm;
                r_asel     <= bus.id_asel;
                r_bsel     <= bus.id_bsel;
                r_rd       <= bus.id_rd;
                r_we       <= bus.id_we;
                r_is_load  <= bus.id_is_load;
            end
        end
    end

    // Retired writes stay visible so an operand frozen in ID/EX across a stall
    // still sees writes that retired while it was held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < HIST_DEPTH; k++) begin
                r_hist_valid[k] <= 1'b0;
                r_hist_rd[k]    <= '0;
                r_hist_data[k]  <= '0;
            end
        end else if (!bus.stall_in && bus.wb_we && (bus.wb_rd != '0)) begin
            r_hist_valid[0] <= 1'b1;
            r_hist_rd[0]    <= bus.wb_rd;
            r_hist_data[0]  <= bus.wb_data;
            for (int k = 1; k < HIST_DEPTH; k++) begin
                r_hist_valid[k] <= r_hist_valid[k-1];
                r_hist_rd[k]    <= r_hist_rd[k-1];
                r_hist_data[k]  <= r_hist_data[k-1];
            end
        end
    end

    // Returns {sel, data}; candidates are applied oldest-first so the newest wins.
    function automatic logic [XLEN+2:0] resolve(input logic [REGW-1:0] rs,
                                                input logic [XLEN-1:0] captured);
        logic [2:0]      sel;
        logic [XLEN-1:0] data;
        sel  = c_SEL_REG;
        data = captured;
        for (int k = HIST_DEPTH - 1; k >= 0; k--) begin
            if (r_hist_valid[k] && (r_hist_rd[k] == rs)) begin
                sel  = c_SEL_HIST + 3'(k);
                data = r_hist_data[k];
            end
        end
        if (bus.wb_we && (bus.wb_rd == rs)) begin
            sel  = c_SEL_WB;
            data = bus.wb_data;
        end
        if (bus.mem_we && !bus.mem_is_load && (bus.mem_rd == rs)) begin
            sel  = c_SEL_MEM;
            data = bus.mem_result;
        end
        if (rs == '0) begin
            sel  = c_SEL_REG;
            data = captured;
        end
        return {sel, data};
    endfunction

    always_comb begin
        w_res_a = resolve(r_rs1, r_rdata1);
        w_res_b = resolve(r_rs2, r_rdata2);
    end

    assign bus.ex_valid      = r_ex_valid;
    assign bus.ex_rd         = r_rd;
    assign bus.ex_we         = r_we;
    assign bus.ex_is_load    = r_is_load;
    assign bus.ex_opa        = r_asel ? r_pc  : w_res_a[XLEN-1:0];
    assign bus.ex_opb        = r_bsel ? r_imm : w_res_b[XLEN-1:0];
    assign bus.ex_store_data = w_res_b[XLEN-1:0];
    assign bus.fwd_sel_a     = w_res_a[XLEN+2:XLEN];
    assign bus.fwd_sel_b     = w_res_b[XLEN+2:XLEN];
    assign bus.hazard_stall  = w_hazard;

endmodule
`default_nettype wire

// File: doc/operand_forward_stage.md
Name: operand_forward_stage

Overview:
- ID/EX operand pipeline stage for the 5-stage RV32 core.
- Registers decoded operands.
- Resolves EX operands A, B and store data by priority forwarding from MEM, WB and a retired-write history buffer.
- Generates the load-use interlock.
- Generalises the fixed 4-way ALU-B select to both operands, a parametrised bypass depth and an internally computed select, replacing externally driven mux selects.

Parameters:
- XLEN, 32, datapath width.
- REGW, 5, register index width.
- HIST_DEPTH, 2, number of retired register writes kept for bypass (1..4).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- stall_in  in  1  global pipeline hold; ID/EX and history freeze.
- flush_in  in  1  insert bubble into ID/EX (branch redirect).
- id_valid  in  1  instruction present in ID.
- id_rs1, id_rs2  in  REGW  source indices.
- id_use_rs1, id_use_rs2  in  1  instruction reads that source.
- id_rdata1, id_rdata2  in  XLEN  register-file read data.
- id_pc, id_imm  in  XLEN  PC and immediate.
- id_asel  in  1  1: operand A = PC, 0: rs1.
- id_bsel  in  1  1: operand B = imm, 0: rs2.
- id_rd  in  REGW  destination index.
- id_we  in  1  writes rd.
- id_is_load  in  1  is a load.
- mem_rd  in  REGW  MEM-stage destination.
- mem_we  in  1  MEM-stage writes rd.
- mem_is_load  in  1  MEM-stage instruction is a load.
- mem_result  in  XLEN  MEM-stage ALU result.
- wb_rd  in  REGW  WB destination.
- wb_we  in  1  WB writes rd.
- wb_data  in  XLEN  WB write data.
- ex_valid  out  1  EX holds a valid instruction.
- ex_rd  out  REGW  registered destination.
- ex_we  out  1  registered write enable.
- ex_is_load  out  1  registered load flag.
- ex_opa, ex_opb  out  XLEN  resolved ALU operands.
- ex_store_data  out  XLEN  resolved rs2 value, independent of bsel.
- fwd_sel_a, fwd_sel_b  out  3  source code: 0 captured regfile value, 1 MEM, 2 WB, 3+k history entry k.
- hazard_stall  out  1  load-use interlock request to IF/ID.

Behaviour:
- Reset (async, immediate): ex_valid=0, all ID/EX fields 0, all history entries invalid. Outputs evaluate from the zeroed state, giving ex_opa=ex_opb=ex_store_data=0 and fwd_sel=0.
- hazard_stall is combinational: id_valid & ex_valid & ex_is_load & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- ID/EX register update, per rising edge, in priority order:
  - flush_in: ex_valid<=0, ex_we<=0; other fields don't care. Flush overrides stall_in.
  - else stall_in: hold all fields.
  - else hazard_stall: bubble, ex_valid<=0, ex_we<=0.
  - else load all id_* fields; ex_valid<=id_valid.
- History buffer: shift register of {valid, rd, data}.
  - On edge with !stall_in & wb_we & wb_rd!=0: entry0<=WB write, entry k<=entry k-1, oldest entry drops.
  - Otherwise hold.
  - Flush does not affect it.
  - Covers operands captured stale while ID/EX was held.
- Forward resolution for each captured source (rs1, rs2), combinational from registered state:
  - Index 0 always resolves to the captured value, sel 0.
  - Else the first match in priority order wins: MEM (mem_we & !mem_is_load & mem_rd==rs) -> 1; WB (wb_we & wb_rd==rs) -> 2; history 0..HIST_DEPTH-1 (valid & rd==rs) -> 3+k; else captured value -> 0.
  - A load in MEM is never forwarded; the interlock guarantees it is in WB when the consumer needs it.
  - When MEM and WB both match, MEM wins (newest).
  - When multiple history entries match, the lowest k wins.
- Operand muxing:
  - ex_opa = ex_asel ? ex_pc : resolved rs1.
  - ex_opb = ex_bsel ? ex_imm : resolved rs2.
  - ex_store_data = resolved rs2 always.
  - fwd_sel_x reports the resolver choice regardless of asel/bsel.
- Latency: operands captured one cycle after ID presentation; forwarding adds no cycles. Load-use costs exactly one bubble.
- No arithmetic; widths pass through unchanged.

Test Plan:
- Back-to-back ALU dependency: addi x5=7, then add x6,x5,x5 with id_rdata=0 -> in EX fwd_sel_a=fwd_sel_b=1, ex_opa=ex_opb=7.
- Load-use: lw x3 in EX, next ID uses rs1=x3 -> hazard_stall=1 for one cycle, EX bubble (ex_valid=0). The following cycle the consumer enters EX with wb_rd=3, wb_data=0x55 -> fwd_sel_a=2, ex_opa=0x55.
- Double match: MEM writes x4=1, WB writes x4=2, EX reads x4 -> fwd_sel=1, operand=1.
- x0 guard: mem_rd=0, mem_we=1, mem_result=0xFFFF, EX reads x0 -> fwd_sel=0, operand=captured 0.
- Stale hold: ID/EX held 3 cycles by stall_in=1 while WB wrote x7=9 just before the hold, captured id_rdata=0 -> after release with no MEM/WB match, fwd_sel=3, operand=9.
- Reset mid-operation: assert rst with ex_valid=1 and history full -> ex_valid=0 immediately, history cleared, and next dependent read uses the captured value (fwd_sel=0); flush_in with stall_in both high -> bubble inserted.
